// File: rtl/ddr_fifo_burst_scheduler_pkg.sv
// Shared types and defaults for the DDR FIFO burst scheduler.
package ddr_fifo_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ARB, ST_WR_CMD, ST_WR_WAIT, ST_RD_CMD, ST_RD_WAIT
  } state_e;

  typedef enum logic {GRANT_RD = 1'b0, GRANT_WR = 1'b1} grant_e;

  localparam int DEF_BURST_BEATS = 64;
  localparam int DEF_BEAT_BYTES  = 64;
  localparam int DEF_SLOT_W      = 17;

  // AXI len field is beats-1.
  function automatic logic [7:0] cmd_len_f(input int beats);
    return 8'(beats - 1);
  endfunction
endpackage

// File: rtl/ddr_fifo_burst_scheduler_if.sv
// Command handshake and completion signals between scheduler and AXI master.
interface ddr_fifo_burst_scheduler_if #(parameter int DDR_ADDR_W = 31);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [DDR_ADDR_W-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic                  wr_done;
  logic                  rd_done;

  modport master (output cmd_valid, cmd_write, cmd_addr, cmd_len,
                  input  cmd_ready, wr_done, rd_done);
  modport slave  (input  cmd_valid, cmd_write, cmd_addr, cmd_len,
                  output cmd_ready, wr_done, rd_done);
endinterface

// File: rtl/ddr_fifo_burst_scheduler_ring_ptr_ctr.sv
// Modulo-2^SLOT_W ring pointer with increment enable and synchronous clear.
module ring_ptr_ctr
  import ddr_fifo_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] ptr_o
);
  logic [SLOT_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i)  ptr_q <= '0;
    else if (inc_i)    ptr_q <= ptr_q + 1'b1;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/ddr_fifo_burst_scheduler.sv
// Arbitrates write/read bursts between staging buffers and a DDR ring,
// tracking fill level, read priming and sticky over/underflow.
module ddr_fifo_burst_scheduler
  import ddr_fifo_pkg::*;
#(
  parameter int                    DDR_ADDR_W  = 31,
  parameter logic [DDR_ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                    SLOT_W      = DEF_SLOT_W,
  parameter int                    BURST_BEATS = DEF_BURST_BEATS,
  parameter int                    BEAT_BYTES  = DEF_BEAT_BYTES,
  parameter int                    LVL_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_work,
  input  logic [31:0]           delay_thread,
  input  logic [LVL_W-1:0]      wr_level,
  input  logic [LVL_W-1:0]      rd_space,
  ddr_fifo_burst_scheduler_if.master bus,
  output logic [SLOT_W:0]       fill_bursts,
  output logic                  primed,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int               ADDR_SHIFT = $clog2(BURST_BEATS * BEAT_BYTES);
  localparam logic [LVL_W-1:0] BURST_LVL  = LVL_W'(BURST_BEATS);

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [SLOT_W:0]       fill_q, fill_d;
  logic                  primed_q, primed_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [DDR_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

  logic                  wr_inc, rd_inc, ptr_clr;
  logic [SLOT_W-1:0]     wr_ptr, rd_ptr;
  logic [DDR_ADDR_W-1:0] wr_addr, rd_addr;
  logic                  ring_full, wr_want, rd_want, wr_elig, rd_elig, prime_hit;

  ring_ptr_ctr #(.SLOT_W(SLOT_W)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr_i(ptr_clr), .inc_i(wr_inc), .ptr_o(wr_ptr)
  );
  ring_ptr_ctr #(.SLOT_W(SLOT_W)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr_i(ptr_clr), .inc_i(rd_inc), .ptr_o(rd_ptr)
  );

  assign wr_addr   = BASE_ADDR + (DDR_ADDR_W'(wr_ptr) << ADDR_SHIFT);
  assign rd_addr   = BASE_ADDR + (DDR_ADDR_W'(rd_ptr) << ADDR_SHIFT);

  // fill_q reaches 2^SLOT_W only when every slot is occupied.
  assign ring_full = fill_q[SLOT_W];
  assign wr_want   = (wr_level >= BURST_LVL);
  assign rd_want   = (rd_space >= BURST_LVL);
  assign wr_elig   = wr_want && !ring_full;
  assign rd_elig   = primed_q && (fill_q != '0) && rd_want;
  // A full ring satisfies any threshold above capacity.
  assign prime_hit = (32'(fill_q) >= delay_thread) || ring_full;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fill_d       = fill_q;
    primed_d     = primed_q || prime_hit;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    wr_inc       = 1'b0;
    rd_inc       = 1'b0;
    ptr_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!start_work) begin
          ptr_clr      = 1'b1;
          fill_d       = '0;
          primed_d     = 1'b0;
          ovf_d        = 1'b0;
          unf_d        = 1'b0;
          last_grant_d = GRANT_RD;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (wr_want && ring_full)                  ovf_d = 1'b1;
        if (primed_q && fill_q == '0 && rd_want)   unf_d = 1'b1;
        if (!start_work) begin
          state_d = ST_IDLE;
        end else if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
          state_d     = ST_WR_CMD;
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b1;
          cmd_addr_d  = wr_addr;
        end else if (rd_elig) begin
          state_d     = ST_RD_CMD;
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = rd_addr;
        end
      end
      ST_WR_CMD: begin
        if (bus.cmd_ready) begin
          cmd_valid_d  = 1'b0;
          wr_inc       = 1'b1;
          last_grant_d = GRANT_WR;
          state_d      = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (bus.wr_done) begin
          fill_d  = fill_q + 1'b1;
          state_d = ST_ARB;
        end
      end
      ST_RD_CMD: begin
        // The slot is released at the handshake, not at completion.
        if (bus.cmd_ready) begin
          cmd_valid_d  = 1'b0;
          rd_inc       = 1'b1;
          last_grant_d = GRANT_RD;
          fill_d       = fill_q - 1'b1;
          state_d      = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.rd_done) state_d = ST_ARB;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      fill_q       <= '0;
      primed_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fill_q       <= fill_d;
      primed_q     <= primed_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_write = cmd_write_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_len   = cmd_len_f(BURST_BEATS);
  assign fill_bursts   = fill_q;
  assign primed        = primed_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
endmodule

// File: tb/tb_ddr_fifo_burst_scheduler.sv
// Directed scoreboard bench for ddr_fifo_burst_scheduler (4-slot ring, 256-byte bursts).
module tb_ddr_fifo_burst_scheduler;
  localparam int DW = 31;

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_work;
  logic [31:0] delay_thread;
  logic [15:0] wr_level;
  logic [15:0] rd_space;
  logic [2:0]  fill_bursts;
  logic        primed, overflow, underflow;

  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];

  ddr_fifo_burst_scheduler_if #(.DDR_ADDR_W(DW)) bus ();

  ddr_fifo_burst_scheduler #(
    .DDR_ADDR_W(DW), .BASE_ADDR(31'h1000), .SLOT_W(2),
    .BURST_BEATS(4), .BEAT_BYTES(64), .LVL_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start_work(start_work), .delay_thread(delay_thread),
    .wr_level(wr_level), .rd_space(rd_space), .bus(bus),
    .fill_bursts(fill_bursts), .primed(primed), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic wr, input logic [DW-1:0] addr);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    sb.push_back(e);
  endtask

  // Waits for the next command, checks it against the scoreboard head, and
  // returns one negedge later (after the handshake when cmd_ready is high).
  task automatic expect_cmd(input string tag, output logic was_wr);
    int   n;
    exp_t e;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e      = sb.pop_front();
    was_wr = e.wr;
    total++;
    assert (n < 40) passed++;
    else $error("FAIL %s_timeout: observed cmd_valid=0 for 40 cycles expected cmd_valid=1", tag);
    chk({tag, "_write"}, 32'(bus.cmd_write), 32'(e.wr));
    chk({tag, "_addr"},  32'(bus.cmd_addr),  32'(e.addr));
    @(negedge clk);
  endtask

  task automatic complete(input logic wr);
    if (wr) bus.wr_done = 1'b1;
    else    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  initial begin
    logic w;
    int   seen;
    rst = 1'b1; start_work = 1'b0; delay_thread = 32'd2;
    wr_level = '0; rd_space = '0;
    bus.cmd_ready = 1'b1; bus.wr_done = 1'b0; bus.rd_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.cmd_valid), 0);
    chk("rst_write", 32'(bus.cmd_write), 0);
    chk("rst_addr",  32'(bus.cmd_addr),  0);
    chk("rst_len",   32'(bus.cmd_len),   3);
    chk("rst_fill",  32'(fill_bursts),   0);
    chk("rst_flags", 32'({primed, overflow, underflow}), 0);
    rst = 1'b0;

    // Stray completions while idle in ARB are ignored.
    start_work = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b1; bus.rd_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0; bus.rd_done = 1'b0;
    @(negedge clk);
    chk("stray_fill",  32'(fill_bursts),   0);
    chk("stray_valid", 32'(bus.cmd_valid), 0);

    // 1: two writes, priming after the second.
    wr_level = 16'd4;
    push(1'b1, 31'h1000);
    expect_cmd("t1_w0", w);
    complete(w);
    chk("t1_fill1",   32'(fill_bursts), 1);
    chk("t1_primed0", 32'(primed),      0);
    push(1'b1, 31'h1100);
    expect_cmd("t1_w1", w);
    complete(w);
    wr_level = 16'd0;
    chk("t1_fill2",      32'(fill_bursts), 2);
    chk("t1_primed_lag", 32'(primed),      0);
    @(negedge clk);
    chk("t1_primed1",    32'(primed),      1);

    // 2: drain both bursts; fill drops at the read handshake.
    rd_space = 16'd8;
    push(1'b0, 31'h1000);
    push(1'b0, 31'h1100);
    expect_cmd("t2_r0", w);
    chk("t2_fill1", 32'(fill_bursts), 1);
    complete(w);
    expect_cmd("t2_r1", w);
    chk("t2_fill0", 32'(fill_bursts), 0);
    complete(w);
    @(negedge clk);
    chk("t5_underflow", 32'(underflow), 1);
    chk("t5_no_ovf",    32'(overflow),  0);

    // 3: preload two bursts, then round-robin with both sides eligible.
    rd_space = 16'd0; wr_level = 16'd4;
    push(1'b1, 31'h1200);
    push(1'b1, 31'h1300);
    expect_cmd("t3_pre0", w); complete(w);
    expect_cmd("t3_pre1", w); complete(w);
    rd_space = 16'd8;
    push(1'b0, 31'h1200); push(1'b1, 31'h1000);
    push(1'b0, 31'h1300); push(1'b1, 31'h1100);
    push(1'b0, 31'h1000); push(1'b1, 31'h1200);
    for (int i = 0; i < 6; i++) begin
      expect_cmd($sformatf("t3_rr%0d", i), w);
      complete(w);
    end
    wr_level = 16'd0;
    chk("t3_fill", 32'(fill_bursts), 2);

    // 5b: start_work drops in RD_WAIT; completion still required before flush.
    push(1'b0, 31'h1100);
    expect_cmd("t5_r", w);
    start_work = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_hold_valid",  32'(bus.cmd_valid), 0);
    chk("t5_hold_fill",   32'(fill_bursts),   1);
    chk("t5_hold_primed", 32'(primed),        1);
    complete(w);
    repeat (3) @(negedge clk);
    chk("t5_flush_fill",  32'(fill_bursts), 0);
    chk("t5_flush_flags", 32'({primed, overflow, underflow}), 0);

    // 4: fill the ring with writes only; overflow the cycle after full.
    rd_space = 16'd0; wr_level = 16'd4; start_work = 1'b1;
    push(1'b1, 31'h1000); push(1'b1, 31'h1100);
    push(1'b1, 31'h1200); push(1'b1, 31'h1300);
    for (int i = 0; i < 4; i++) begin
      expect_cmd($sformatf("t4_w%0d", i), w);
      complete(w);
    end
    chk("t4_fill",     32'(fill_bursts), 4);
    chk("t4_ovf_lag",  32'(overflow),    0);
    @(negedge clk);
    chk("t4_ovf",      32'(overflow),    1);
    chk("t4_primed",   32'(primed),      1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cmd_valid) seen++;
    end
    chk("t4_no_cmd", 32'(seen), 0);

    // 6: back-pressure holds the command stable; reset mid-wait.
    start_work = 1'b0; wr_level = 16'd0;
    repeat (3) @(negedge clk);
    chk("t6_flushed", 32'(fill_bursts), 0);
    bus.cmd_ready = 1'b0; start_work = 1'b1; wr_level = 16'd4;
    push(1'b1, 31'h1000);
    expect_cmd("t6_w", w);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6_stable_valid%0d", i), 32'(bus.cmd_valid), 1);
      chk($sformatf("t6_stable_addr%0d", i),  32'(bus.cmd_addr),  32'h1000);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(bus.cmd_valid), 0);
    chk("t6_rst_write", 32'(bus.cmd_write), 0);
    chk("t6_rst_addr",  32'(bus.cmd_addr),  0);
    chk("t6_rst_fill",  32'(fill_bursts),   0);
    chk("t6_rst_flags", 32'({primed, overflow, underflow}), 0);
    rst = 1'b0; bus.cmd_ready = 1'b1;
    @(negedge clk);
    chk("t6_idle_first", 32'(bus.cmd_valid), 0);
    push(1'b1, 31'h1000);
    expect_cmd("t6_after_rst", w);
    complete(w);
    chk("t6_after_fill", 32'(fill_bursts), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ddr_fifo_burst_scheduler.md
# ddr_fifo_burst_scheduler

Sequences all DDR traffic for the DDR-backed FIFO path that carries ADC samples to the DAC. It sits between the write/read staging buffers and the MIG AXI master. It decides when a full burst is written from the write staging buffer into a DDR ring, and when a burst is read back into the read staging buffer. It tracks ring pointers and fill level, and holds reads off until the programmed delay (`delay_thread`) has accumulated.

## Interface
- `DDR_ADDR_W`, 31: width of the DDR byte address.
- `BASE_ADDR`, 0: DDR byte address of ring slot 0.
- `SLOT_W`, 17: log2 of the ring capacity in bursts.
- `BURST_BEATS`, 64: beats per burst (power of two, 2–256).
- `BEAT_BYTES`, 64: bytes per beat (power of two).
- `LVL_W`, 16: width of the staging-buffer level inputs.

Ports:
- `clk`  in  1  UI clock; all logic is on this single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_work`  in  1  level enable. While low and idle, the ring is flushed.
- `delay_thread`  in  32  read-start threshold, in bursts.
- `wr_level`  in  LVL_W  beats available in the write staging buffer.
- `rd_space`  in  LVL_W  free beats in the read staging buffer.
- `cmd_valid`  out  1  command offered to the AXI master.
- `cmd_ready`  in  1  the AXI master accepts the command.
- `cmd_write`  out  1  1 = write burst, 0 = read burst.
- `cmd_addr`  out  DDR_ADDR_W  burst start byte address.
- `cmd_len`  out  8  AXI len, constant `BURST_BEATS-1`.
- `wr_done`  in  1  one-cycle pulse on the write B response.
- `rd_done`  in  1  one-cycle pulse on the last R beat.
- `fill_bursts`  out  SLOT_W+1  number of bursts resident in DDR.
- `primed`  out  1  the read threshold has been reached since the last flush.
- `overflow`  out  1  sticky: a write was pending while the ring was full.
- `underflow`  out  1  sticky: primed, ring empty, and the read side was starving.

## Operation
**States:** IDLE, ARB, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT. At most one command is outstanding at a time.

**Eligibility terms:**
- `wr_elig` = `wr_level >= BURST_BEATS` and `fill_bursts < 2^SLOT_W`.
- `rd_elig` = `primed` and `fill_bursts != 0` and `rd_space >= BURST_BEATS`.

**State transitions:**
- IDLE:
  - If `start_work` = 0: clear `wr_ptr`, `rd_ptr`, `fill_bursts`, `primed`, `overflow`, `underflow`, and `last_grant`.
  - If `start_work` = 1: go to ARB.
- ARB:
  - If `start_work` = 0: go to IDLE.
  - Only `wr_elig`: go to WR_CMD.
  - Only `rd_elig`: go to RD_CMD.
  - Both: round-robin, opposite of `last_grant`.
  - Neither: stay in ARB.
- WR_CMD / RD_CMD:
  - Hold `cmd_valid` = 1 with stable `cmd_*` until `cmd_ready`.
  - On the handshake, advance the relevant pointer modulo `2^SLOT_W` and record `last_grant`.
  - A read handshake also decrements `fill_bursts`.
  - Then go to WR_WAIT / RD_WAIT.
- WR_WAIT:
  - On `wr_done`, increment `fill_bursts`, then go to ARB.
- RD_WAIT:
  - On `rd_done`, go to ARB.

**Addressing:** `cmd_addr = BASE_ADDR + ptr * BURST_BEATS * BEAT_BYTES`, truncated to `DDR_ADDR_W`. The multiply is a shift.

**Priming:**
- `primed` sets when `fill_bursts >= min(delay_thread, 2^SLOT_W)`.
- It stays set until flushed.
- `delay_thread` = 0 means reads may start immediately once `fill_bursts` > 0.

**Error flags:**
- `overflow` sets in ARB when `wr_level >= BURST_BEATS` and the ring is full.
- `underflow` sets in ARB when `primed`, `fill_bursts` = 0, and `rd_space >= BURST_BEATS`.

**`start_work` dropping mid-transaction:** the command and its completion run to the end. The FSM then goes ARB → IDLE, and the flush happens in IDLE.

**Stray completions:** `wr_done` or `rd_done` arriving outside its WAIT state is ignored.

## Timing
- Every output resets to 0 (`cmd_len` is the constant `BURST_BEATS-1`). Pointers reset to 0 and the state resets to IDLE.
- Eligibility true in ARB at cycle N gives `cmd_valid` = 1 at N+1.
- `cmd_*` are registered and do not depend combinationally on `cmd_ready`.
- `fill_bursts`:
  - Updates the cycle after `wr_done` or the read handshake.
  - `primed` follows `fill_bursts` by one cycle.
- After a completion pulse, ARB is entered the next cycle. The minimum spacing between consecutive commands is therefore 2 cycles after the completion.
- A `cmd_ready` that is high while `cmd_valid` = 0 has no effect.

## Structure
- Shared package `ddr_fifo_pkg` holds:
  - the state enum;
  - the `BURST_BEATS`, `BEAT_BYTES`, and `SLOT_W` defaults;
  - the `cmd_len` constant.
- Optional sub-module `ring_ptr_ctr`: a modulo-`2^SLOT_W` pointer with increment enable and synchronous clear, instantiated twice.
- The remainder is a single FSM with its counters.

## Test plan
Bench parameters: `SLOT_W`=2, `BURST_BEATS`=4, `BEAT_BYTES`=64, `BASE_ADDR`=0x1000, `delay_thread`=2, and `cmd_ready` tied high unless stated.

1. `wr_level`=4, one write round trip → `cmd_write`=1, `cmd_addr`=0x1000; after `wr_done`, `fill_bursts`=1 and `primed`=0. A second write goes to 0x1100, then `fill_bursts`=2 and `primed`=1.
2. Primed, `fill_bursts`=2, `rd_space`=8, `wr_level`=0 → read at 0x1000 with `fill_bursts`=1 after the handshake; the next read is at 0x1100 and `fill_bursts` then reaches 0.
3. Both eligible for 6 commands with `last_grant`=write → sequence is R, W, R, W, R, W. Ring pointers wrap: the fifth write is at 0x1000.
4. 4 writes with no reads and `wr_level` held at 4 → `fill_bursts`=4, no further `cmd_valid`, and `overflow`=1 next cycle.
5. Primed, ring drained, `rd_space`=8 → `underflow`=1. Dropping `start_work` in RD_WAIT leaves RD_WAIT only on `rd_done`; in IDLE all flags and `fill_bursts` return to 0.
6. `cmd_ready` held low for 5 cycles in WR_CMD → `cmd_valid` and `cmd_addr` are stable; `rst`=1 mid-wait → all outputs 0 next cycle and state is IDLE.
